// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM state type and NZCV flag layout for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_ORR   = 4'b0100;
  localparam logic [3:0] OP_EOR   = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b1100;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_PASSA = 4'b0111;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b0011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// The first partial product is folded into the start cycle so the result is ready WIDTH-1 cycles later.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  logic             busy_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = busy_q && (cnt_q == '0);
  assign prod_o   = acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      acc_q    <= b_i[0] ? a_i : '0;
      mcand_q  <= a_i << 1;
      mplier_q <= b_i >> 1;
      cnt_q    <= SHW'(WIDTH - 2);
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative MUL, registered result with NZCV.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             accept, is_mul, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (in_op == OP_MUL);

  assign sum_add = {1'b0, in_a} + {1'b0, in_b};
  assign sum_sub = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:   alu_res = in_a & in_b;
      OP_ORR:   alu_res = in_a | in_b;
      OP_EOR:   alu_res = in_a ^ in_b;
      OP_NOR:   alu_res = ~(in_a | in_b);
      OP_NAND:  alu_res = ~(in_a & in_b);
      OP_MOV:   alu_res = in_b;
      OP_PASSA: alu_res = in_a;
      OP_LSL:   alu_res = in_a << in_b[SHW-1:0];
      OP_LSR:   alu_res = in_a >> in_b[SHW-1:0];
      OP_MUL:   alu_res = '0; // produced by the multiplier, never loaded from here
      default:  alu_err = 1'b1;
    endcase
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && is_mul),
    .a_i     (in_a),
    .b_i     (in_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? BUSY : DONE;
      BUSY:    if (mul_done) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? (is_mul ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && !is_mul) begin
      result_d = alu_res;
      flags_d  = pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);
      err_d    = alu_err;
    end else if (mul_done) begin
      result_d = mul_prod;
      flags_d  = pack_flags(mul_prod[WIDTH-1], mul_prod == '0, 1'b0, 1'b0);
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops them on each output handshake.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [3:0]    in_op = '0;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic          out_err;

  logic          in_valid8 = 1'b0, in_ready8;
  logic [7:0]    in_a8 = '0, in_b8 = '0;
  logic [3:0]    in_op8 = '0;
  logic          out_valid8, out_ready8 = 1'b1;
  logic [7:0]    out_result8;
  logic [3:0]    out_flags8;
  logic          out_err8;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags), .out_err(out_err)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_result(out_result8), .out_flags(out_flags8), .out_err(out_err8)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    int          vis;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  bit   front_seen = 0;
  int   hold_cnt = 0;
  int   rdy_pct = 100;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: true-integer arithmetic, then wrap to 32 bits.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, wide;
    longint sa, sb, sr;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 0; v = 0; e.err = 0; e.res = '0;
    case (op)
      4'b0010: begin wide = ua + ub; e.res = wide[31:0]; c = wide[32];
                     sr = sa + sb; v = (sr != longint'($signed(e.res))); end
      4'b1010: begin e.res = a - b; c = (a >= b);
                     sr = sa - sb; v = (sr != longint'($signed(e.res))); end
      4'b0110: e.res = a & b;
      4'b0100: e.res = a | b;
      4'b1001: e.res = a ^ b;
      4'b0101: e.res = ~(a | b);
      4'b1100: e.res = ~(a & b);
      4'b1101: e.res = b;
      4'b0111: e.res = a;
      4'b1000: e.res = a << (b % 32);
      4'b1011: e.res = a >> (b % 32);
      4'b0011: begin wide = ua * ub; e.res = wide[31:0]; end
      default: e.err = 1;
    endcase
    e.flags = {e.res[31], e.res == 0, c, v};
    e.name  = $sformatf("op%b_%h_%h", op, a, b);
    e.vis   = 0;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int tries;
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    #1;
    tries = 0;
    while (!in_ready && tries < 200) begin
      @(negedge clk); #1; tries++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 0;
      return;
    end
    e = model(op, a, b);
    e.vis = cyc + 1 + ((op == 4'b0011) ? W - 1 : 0);
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor
  initial begin
    out_ready = 1;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) out_ready = 0;
      else              out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (rst_n) begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else begin
            if (!front_seen) begin
              check({sb_q[0].name, "_latency"}, cyc, sb_q[0].vis);
              front_seen = 1;
            end
            check({sb_q[0].name, "_result"}, out_result, sb_q[0].res);
            check({sb_q[0].name, "_flags"}, out_flags, sb_q[0].flags);
            check({sb_q[0].name, "_err"}, out_err, sb_q[0].err);
            if (!out_ready) begin
              check("stall_in_ready", in_ready, 0);
              if (hold_cnt > 0) hold_cnt--;
            end else begin
              void'(sb_q.pop_front());
              front_seen = 0;
            end
          end
        end else if (sb_q.size() > 0) begin
          check("busy_in_ready", in_ready, 0);
        end
      end
    end
  end

  initial begin
    int n;
    #2 rst_n = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_err", out_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    @(negedge clk);

    send(OP_ADD, 32'd5, 32'd4);
    send(OP_SUB, 32'd4, 32'd4);
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    send(OP_SUB, 32'd0, 32'd1);
    send(OP_MUL, 32'h1234, 32'h10);
    send(OP_NOR, 32'd5, 32'd4);
    hold_cnt = 5;
    send(OP_ORR, 32'd5, 32'd4);
    send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'b1111, 32'd7, 32'd9);
    send(OP_ADD, 32'd1, 32'd1);
    repeat (3) @(negedge clk);

    rdy_pct = 70;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) @(negedge clk);
      send(4'($urandom_range(15)), pick(), pick());
    end

    rdy_pct = 100;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain_empty", sb_q.size(), 0);

    send(OP_MUL, 32'hDEAD_BEEF, 32'h1357);
    repeat (9) @(negedge clk);
    rst_n = 0;
    sb_q.delete();
    front_seen = 0;
    #1;
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_result", out_result, 0);
    check("midmul_rst_flags", out_flags, 0);
    check("midmul_rst_err", out_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("midmul_release_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    #1;
    check("midmul_no_stale_valid", out_valid, 0);
    @(negedge clk);
    send(OP_MUL, 32'd3, 32'd7);
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("post_rst_mul_drain", sb_q.size(), 0);

    // Narrow instance: multiply wraps to zero, then a full-scale product.
    for (int t = 0; t < 2; t++) begin
      in_valid8 = 1;
      in_op8    = OP_MUL;
      in_a8     = (t == 0) ? 8'h10 : 8'h0F;
      in_b8     = (t == 0) ? 8'h10 : 8'h11;
      #1;
      check("w8_in_ready", in_ready8, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 0;
      n = 1;
      #1;
      while (!out_valid8 && n < 40) begin @(negedge clk); #1; n++; end
      check("w8_latency", n, 8);
      check("w8_result", out_result8, (t == 0) ? 8'h00 : 8'hFF);
      check("w8_flags", out_flags8, (t == 0) ? 4'b0100 : 4'b1000);
      check("w8_err", out_err8, 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
